// File: rtl/hough_peak_finder.sv
// Raster-sweeps the Hough accumulator once per start and reports the highest-vote cell as the circle centre.
// Define ACC_CLEAR_EN to zero each accumulator cell one cycle behind the read pointer.
module hough_peak_finder #(
  parameter int unsigned ROW_LENGTH = 450,
  parameter int unsigned COL_LENGTH = 290,
  parameter int unsigned X_BIAS     = 95,
  parameter int unsigned Y_BIAS     = 95,
  parameter int unsigned VOTE_W     = 4,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned MIN_VOTES  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [VOTE_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [VOTE_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [VOTE_W-1:0] peak_votes,
  output logic [9:0]        idealX,
  output logic [8:0]        idealY
);

  localparam int unsigned X_W = (ROW_LENGTH > 1) ? $clog2(ROW_LENGTH) : 1;
  localparam int unsigned Y_W = (COL_LENGTH > 1) ? $clog2(COL_LENGTH) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(ROW_LENGTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(COL_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  state_e            state_q;
  logic [X_W-1:0]    x_q, xd_q, xmax_q, xmax_d;
  logic [Y_W-1:0]    y_q, yd_q, ymax_q, ymax_d;
  logic [ADDR_W-1:0] addr_q;
  logic              vld_q;
  logic [VOTE_W-1:0] max_q, max_d;
  logic              busy_q, done_q, found_q, found_d;
  logic [VOTE_W-1:0] peak_q;
  logic [9:0]        ix_q, ix_d;
  logic [8:0]        iy_q, iy_d;
  logic              last_cell;

  assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);

  // The final datum arrives during DRAIN, so the DONE-cycle results are taken from the combinational next max.
  always_comb begin
    max_d  = max_q;
    xmax_d = xmax_q;
    ymax_d = ymax_q;
    if (vld_q && (rd_data > max_q)) begin
      max_d  = rd_data;
      xmax_d = xd_q;
      ymax_d = yd_q;
    end
    found_d = (32'(max_d) >= MIN_VOTES);
    ix_d    = 10'(xmax_d) + 10'(X_BIAS);
    iy_d    = 9'(ymax_d) + 9'(Y_BIAS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xd_q    <= '0;
      yd_q    <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      max_q   <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      peak_q  <= '0;
      ix_q    <= '0;
      iy_q    <= '0;
    end else begin
      xd_q   <= x_q;
      yd_q   <= y_q;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      max_q  <= max_d;
      xmax_q <= xmax_d;
      ymax_q <= ymax_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            max_q   <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
          end
        end
        SCAN: begin
          vld_q <= 1'b1;
          if (last_cell) begin
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          peak_q  <= max_d;
          found_q <= found_d;
          if (found_d) begin
            ix_q <= ix_d;
            iy_q <= iy_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ACC_CLEAR_EN
  logic [ADDR_W-1:0] addr_dly_q;

  always_ff @(posedge clk) begin
    if (rst) addr_dly_q <= '0;
    else     addr_dly_q <= addr_q;
  end

  assign wr_en   = vld_q;
  assign wr_addr = addr_dly_q;
  assign wr_data = '0;
`else
  assign wr_en   = 1'b0;
  assign wr_addr = '0;
  assign wr_data = '0;
`endif

  assign rd_addr    = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign peak_votes = peak_q;
  assign idealX     = ix_q;
  assign idealY     = iy_q;

endmodule

// File: doc/hough_peak_finder.md
# hough_peak_finder

Downstream stage of the Hough circle accumulator: after a frame's voting completes, it sweeps the accumulator BRAM read port once in raster order and finds the cell with the highest vote count. It converts that cell's index to frame coordinates and reports it as the detected circle centre. With the clear feature compiled in, it also zeroes each cell behind the read pointer, so the accumulator is empty for the next frame.

## Interface
Parameters:
- ROW_LENGTH, 450, accumulator cells per row (x extent)
- COL_LENGTH, 290, accumulator rows (y extent)
- X_BIAS, 95, added to cell x index to form frame X
- Y_BIAS, 95, added to cell y index to form frame Y
- VOTE_W, 4, vote/cell width
- ADDR_W, 18, accumulator address width
- MIN_VOTES, 3, minimum peak count accepted as a detection

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to scan; honoured only in IDLE
- rd_addr  out  ADDR_W  accumulator read address
- rd_data  in  VOTE_W  accumulator read data, 1-cycle registered latency
- wr_en  out  1  clear-write enable to accumulator
- wr_addr  out  ADDR_W  clear-write address
- wr_data  out  VOTE_W  clear-write data (always 0)
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse; results valid that cycle and held afterwards
- found  out  1  last scan's peak was >= MIN_VOTES
- peak_votes  out  VOTE_W  last scan's maximum count
- idealX  out  10  detected centre X
- idealY  out  9  detected centre Y

## Operation
- States: IDLE → SCAN → DRAIN → DONE → IDLE.
- IDLE: start=1 enters SCAN and clears the running max, the x/y counters and the address. start is ignored in every other state.
- SCAN: rd_addr = y*ROW_LENGTH + x, produced by an incrementing counter (no multiplier).
  - x increments every cycle. At x=ROW_LENGTH-1, x wraps to 0 and y increments.
  - When the last cell is issued (x=ROW_LENGTH-1, y=COL_LENGTH-1), the next state is DRAIN.
- Compare pipeline: x, y and the address are delayed one cycle to align with rd_data.
  - Update the running max when rd_data > max_votes (strict), capturing the delayed x and y.
  - Ties keep the earliest (lowest-address) cell.
  - Initial max is 0, so an all-zero accumulator yields cell (0,0) with peak 0.
- DRAIN: consumes the final read datum; no new address is issued.
- DONE: registers the outputs and asserts done for one cycle.
  - peak_votes is set to the max.
  - found is set to (max >= MIN_VOTES).
  - If found, idealX = xmax + X_BIAS and idealY = ymax + Y_BIAS, computed at 10/9 bits, truncating.
  - If not found, idealX and idealY keep their previous values.
- Reset (any state, including mid-scan): state IDLE; every output is 0 (rd_addr, wr_en, wr_addr, wr_data, busy, done, found, peak_votes, idealX, idealY). A reset mid-scan leaves the accumulator partially cleared; this is accepted.
- busy=1 in SCAN, DRAIN and DONE. busy=0 in IDLE.

## Timing
- Let N = ROW_LENGTH*COL_LENGTH (130500 by default). Start is sampled high at edge 0.
- rd_addr = k is driven during cycle k+1, for k = 0..N-1.
- rd_data for address k is compared during cycle k+2.
- DRAIN occupies cycle N+1.
- done is high in cycle N+2, with results valid in the same cycle.
- Total latency from start to done: N+2 cycles.
- start asserted in the cycle done is high is ignored. The next start is accepted from cycle N+3.
- rd_addr holds its last value outside SCAN.

## Configuration
- ACC_CLEAR_EN defined:
  - wr_en=1 in every cycle a datum is compared (cycles 2..N+1).
  - wr_addr = the delayed address, i.e. the cell just read; wr_data=0.
  - The write lags the read by one address, so there is never a same-cycle read/write conflict on one cell.
  - After done, all N cells read 0.
- ACC_CLEAR_EN undefined: wr_en, wr_addr and wr_data are tied 0, and the accumulator contents are preserved.

## Test plan
- Use ROW_LENGTH=8, COL_LENGTH=4, biases 95, MIN_VOTES=3. BRAM model holds a single 9 at address 13, all else 0 → done at cycle 34; idealX=100, idealY=96, peak_votes=9, found=1.
- Tie: value 7 at addresses 5 and 20 → idealX=100, idealY=95 (first wins).
- All cells 2 → found=0, peak_votes=2; idealX/idealY unchanged from the prior scan.
- start re-pulsed at cycles 10 and 34 → ignored; exactly one done, and busy drops at cycle 35.
- rst at cycle 15 mid-scan → all outputs 0 next cycle, state IDLE; a new start then gives correct results after 34 cycles.
- ACC_CLEAR_EN defined: after done, every cell is 0 and wr_en was high for exactly 32 cycles. Undefined: wr_en never asserts and memory is unchanged.
